// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared constants and helpers for the SPI target.
package spi_target_pkg;

    localparam int SPI_BITS    = 8;
    localparam int SYNC_STAGES = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_target_pin_sync.sv
// spi_pin_sync: 2-FF synchronizer with registered rise/fall pulses.
// Edges are suppressed until the pipeline holds real samples, so a pin already low at reset exit is not seen as a fall.
module spi_pin_sync
    import spi_target_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic pclk,
    input  logic resetq,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge pclk or negedge resetq) begin
        if (!resetq) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            fill_q <= '0;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= s;
            rise_q <= fill_q[SYNC_STAGES] & s & ~prev_q;
            fall_q <= fill_q[SYNC_STAGES] & ~s & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder with RX FIFO and TX holding register on a buart-style CPU handshake.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic       pclk,
    input  logic       resetq,
    input  logic       sck_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic       rd_i,
    input  logic       wr_i,
    input  logic [7:0] tx_data_i,
    output logic [7:0] rx_data_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       frame_o,
    output logic       frame_end_o
);

    localparam int PW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(SPI_BITS);

    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;

    logic          frame_q, frame_d;
    logic          frame_end_q, frame_end_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lp_q, lp_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic load_evt, take, push_req, push, pop, fifo_full, fifo_empty;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sck (
        .pclk   (pclk),
        .resetq (resetq),
        .d_i    (sck_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs (
        .pclk   (pclk),
        .resetq (resetq),
        .d_i    (cs_n_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    always_comb begin
        frame_d     = frame_q;
        frame_end_d = 1'b0;
        cnt_d       = cnt_q;
        lp_d        = lp_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        push_req    = 1'b0;
        load_evt    = 1'b0;
        if (cs_fall) begin
            frame_d  = 1'b1;
            cnt_d    = '0;
            lp_d     = 1'b0;
            load_evt = 1'b1;
        end else if (cs_rise) begin
            frame_end_d = frame_q;
            frame_d     = 1'b0;
            cnt_d       = '0;
            lp_d        = 1'b0;
        end else if (frame_q && sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_q[SYNC_STAGES-1]};
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CW'(SPI_BITS - 1)) begin
                push_req = 1'b1;
                lp_d     = 1'b1;
            end
        end else if (frame_q && sck_fall) begin
            if (lp_q) begin
                load_evt = 1'b1;
                lp_d     = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
        end
        if (load_evt) tx_shift_d = busy_q ? hold_q : IDLE_BYTE;
    end

    // A wr coinciding with a load refills the holding register behind the byte being loaded.
    always_comb begin
        take   = load_evt & busy_q;
        hold_d = hold_q;
        busy_d = busy_q;
        if (wr_i && (!busy_q || take)) begin
            hold_d = tx_data_i;
            busy_d = 1'b1;
        end else if (take) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        fifo_full  = count_q == (PW+1)'(FIFO_DEPTH);
        fifo_empty = count_q == '0;
        pop        = rd_i & ~fifo_empty;
        push       = push_req & (~fifo_full | pop);
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(pop);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        overrun_d  = (rd_i && overrun_q) ? 1'b0 : (overrun_q | (push_req & ~push));
    end

    always_ff @(posedge pclk or negedge resetq) begin
        if (!resetq) begin
            mosi_q      <= '0;
            frame_q     <= 1'b0;
            frame_end_q <= 1'b0;
            cnt_q       <= '0;
            lp_q        <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= IDLE_BYTE;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            frame_q     <= frame_d;
            frame_end_q <= frame_end_d;
            cnt_q       <= cnt_d;
            lp_q        <= lp_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem_q[wptr_q] <= rx_shift_d;
    end

    assign miso_o      = tx_shift_q[7];
    assign miso_oe_o   = frame_q;
    assign rx_data_o   = fifo_empty ? 8'h00 : mem_q[rptr_q];
    assign valid_o     = ~fifo_empty;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;
    assign frame_o     = frame_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed self-checking bench for spi_target.
module tb_spi_target;

    localparam int H = 6;

    logic       pclk = 1'b0;
    logic       resetq = 1'b0;
    logic       sck_i = 1'b0;
    logic       cs_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       rd_i = 1'b0;
    logic       wr_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       miso_o, miso_oe_o, valid_o, busy_o, overrun_o, frame_o, frame_end_o;
    logic [7:0] rx_data_o;

    int n_assert = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int fe_snap;
    logic [7:0] mi;

    spi_target dut (
        .pclk        (pclk),
        .resetq      (resetq),
        .sck_i       (sck_i),
        .cs_n_i      (cs_n_i),
        .mosi_i      (mosi_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .rd_i        (rd_i),
        .wr_i        (wr_i),
        .tx_data_i   (tx_data_i),
        .rx_data_o   (rx_data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .frame_o     (frame_o),
        .frame_end_o (frame_end_o)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (frame_end_o) fe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic pop;
        @(negedge pclk) rd_i = 1'b1;
        @(negedge pclk) rd_i = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge pclk) begin wr_i = 1'b1; tx_data_i = d; end
        @(negedge pclk) wr_i = 1'b0;
    endtask

    task automatic cs_start;
        cs_n_i = 1'b0;
        cyc(8);
    endtask

    task automatic cs_end;
        cyc(H);
        cs_n_i = 1'b1;
        cyc(8);
    endtask

    // rd_at_push raises rd exactly on the pclk edge where the last bit's push lands.
    task automatic xfer(input logic [7:0] mo, input int n, input bit rd_at_push, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi_i = mo[7-i];
            cyc(H);
            got = {got[6:0], miso_o};
            sck_i = 1'b1;
            if (rd_at_push && i == n - 1) begin
                cyc(3);
                rd_i = 1'b1;
                cyc(1);
                rd_i = 1'b0;
                cyc(H - 4);
            end else begin
                cyc(H);
            end
            sck_i = 1'b0;
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_in_miso", miso_o, 1);
        chk("rst_in_oe", miso_oe_o, 0);
        resetq = 1'b1;
        cyc(6);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_frame_end", frame_end_o, 0);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_miso", miso_o, 1);

        cs_start;
        chk("t1_frame", frame_o, 1);
        chk("t1_oe", miso_oe_o, 1);
        xfer(8'hA5, 8, 0, mi);
        cs_end;
        chk("t1_miso_rx", mi, 8'hFF);
        chk("t1_valid", valid_o, 1);
        chk("t1_rx", rx_data_o, 8'hA5);
        chk("t1_fe_cnt", fe_cnt, 1);
        chk("t1_frame_off", frame_o, 0);
        pop;
        chk("t1_empty", valid_o, 0);
        chk("t1_rx_empty", rx_data_o, 8'h00);

        load(8'h3C);
        chk("t2_busy_set", busy_o, 1);
        load(8'h99);
        cs_start;
        chk("t2_busy_clr", busy_o, 0);
        xfer(8'h11, 8, 0, mi);
        chk("t2_mi0", mi, 8'h3C);
        xfer(8'h22, 8, 0, mi);
        chk("t2_mi1", mi, 8'hFF);
        cs_end;
        chk("t2_rx0", rx_data_o, 8'h11);
        pop;
        chk("t2_rx1", rx_data_o, 8'h22);
        pop;
        chk("t2_empty", valid_o, 0);

        cs_start;
        for (int b = 1; b <= 5; b++) xfer(8'(b), 8, 0, mi);
        cs_end;
        chk("t3_mi", mi, 8'hFF);
        chk("t3_overrun", overrun_o, 1);
        chk("t3_head", rx_data_o, 8'h01);
        pop;
        chk("t3_ovr_clr", overrun_o, 0);
        chk("t3_rx2", rx_data_o, 8'h02);
        pop;
        chk("t3_rx3", rx_data_o, 8'h03);
        pop;
        chk("t3_rx4", rx_data_o, 8'h04);
        pop;
        chk("t3_drop5", valid_o, 0);

        cs_start;
        for (int b = 1; b <= 4; b++) xfer(8'(b * 16), 8, 0, mi);
        xfer(8'h50, 8, 1, mi);
        cs_end;
        chk("t4_no_ovr", overrun_o, 0);
        chk("t4_rx0", rx_data_o, 8'h20);
        pop;
        chk("t4_rx1", rx_data_o, 8'h30);
        pop;
        chk("t4_rx2", rx_data_o, 8'h40);
        pop;
        chk("t4_rx3", rx_data_o, 8'h50);
        pop;
        chk("t4_empty", valid_o, 0);

        cs_start;
        xfer(8'hF0, 5, 0, mi);
        cs_end;
        chk("t5_partial", valid_o, 0);
        cs_start;
        xfer(8'h81, 8, 0, mi);
        cs_end;
        chk("t5_rx", rx_data_o, 8'h81);
        pop;

        cs_start;
        load(8'h77);
        chk("t6_busy", busy_o, 1);
        xfer(8'h5A, 4, 0, mi);
        fe_snap = fe_cnt;
        resetq = 1'b0;
        cyc(1);
        chk("t6_miso", miso_o, 1);
        chk("t6_oe", miso_oe_o, 0);
        chk("t6_frame", frame_o, 0);
        chk("t6_busy_rst", busy_o, 0);
        chk("t6_valid", valid_o, 0);
        cyc(2);
        resetq = 1'b1;
        cyc(8);
        chk("t6_no_frame", frame_o, 0);
        cs_n_i = 1'b1;
        cyc(8);
        chk("t6_no_fe", fe_cnt, fe_snap);
        cs_start;
        xfer(8'h5A, 8, 0, mi);
        cs_end;
        chk("t6_mi", mi, 8'hFF);
        chk("t6_rx", rx_data_o, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
